stack_lifo: RTL and testbench
=============================

Name: stack_lifo

Overview:
- Full push/pop LIFO stack; the read/drain side for the push-only stack datapath.
- The top two entries are held in registers and driven out directly.
- Deeper entries live in a synchronous 1R1W RAM with one-cycle read latency.
- A pop that must refill the second slot from RAM costs one extra cycle, with ready deasserted during the refill.

Parameters:
- WIDTH, 16, data word width.
- DEPTH, 1000, maximum number of stacked entries (must be ≥ 3).
- CW, $clog2(DEPTH+1), width of count; 10 for the defaults.

Ports:
- clk  input  1  single clock, rising edge.
- norst  input  1  reset, asynchronous, active-low.
- push  input  1  push request; sampled only when ready=1.
- pop  input  1  pop request; sampled only when ready=1.
- data  input  WIDTH  word to push.
- out1  output  WIDTH  top of stack; 0 when count=0.
- out2  output  WIDTH  second entry; 0 when count<2.
- count  output  CW  number of stored entries.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- ready  output  1  1 in IDLE, 0 in REFILL.
- overflow  output  1  one-cycle pulse on a rejected push.
- underflow  output  1  one-cycle pulse on a rejected pop.

Behaviour:
- Reset: norst=0 immediately forces top=0, second=0, count=0, state=IDLE, overflow=0, underflow=0. Outputs are then out1=0, out2=0, empty=1, full=0, ready=1. RAM contents are don't-care.
- Storage map: entry i (0 = bottom) is stored in RAM[i] for i < count-2. Entry count-2 is held in second; entry count-1 is held in top.
- FSM states: IDLE, REFILL.
- IDLE, push only, !full:
  - top<=data, second<=top, count<=count+1.
  - If count≥2, RAM[count-2]<=second in the same edge.
  - 1-cycle latency; stays in IDLE.
- IDLE, push only, full: no state change; overflow=1 for one cycle.
- IDLE, pop only, count==0: no change; underflow=1 for one cycle.
- IDLE, pop only, count==1: top<=0, count<=0.
- IDLE, pop only, count==2: top<=second, second<=0, count<=1.
- IDLE, pop only, count≥3:
  - top<=second, count<=count-1.
  - Issue RAM read at address count-3; go to REFILL.
- REFILL: second<=RAM read data; go to IDLE. push/pop are ignored, with no overflow or underflow pulse. Upstream must hold requests until ready=1.
- IDLE, push and pop together: replace top.
  - top<=data; count and second unchanged; no RAM access.
  - At count==0 this behaves as a push.
  - Never raises overflow, including when full.
- count never wraps: saturation is enforced by the overflow/underflow rules above.
- out1/out2 are registered values: zero-masked by count, glitch-free, no combinational path from the inputs.
- Reset asserted mid-REFILL: abort immediately to IDLE with count=0; the pending read result is discarded.
- All arithmetic is unsigned at CW bits. RAM addresses are the low $clog2(DEPTH) bits.

Decomposition:
- Package stack_pkg:
  - typedef state_t {IDLE, REFILL}.
  - Default constants WIDTH_D=16 and DEPTH_D=1000.
- Sub-module stack_ram:
  - Parameterised WIDTH/DEPTH.
  - Ports: clk, rd, wr, rdaddr, wraddr, in, result.
  - Synchronous read registered on the posedge; no reset on the array.
- stack_lifo holds the FSM, top/second/count registers, flag logic and the stack_ram instance.

Test Plan:
1. Reset: hold norst=0 for 2 cycles, then release → out1=0, out2=0, count=0, empty=1, full=0, ready=1.
2. Push sequence: push 0x0005, 0x0007, 0x0009 on consecutive cycles → out1=0x0009, out2=0x0007, count=3; RAM[0]=0x0005.
3. Pop with refill at count=3:
   - Pop edge → out1=0x0007, count=2, ready=0.
   - Next edge → out2=0x0005, ready=1.
   - Pop twice more → count=0, out1=0, out2=0, empty=1.
4. Simultaneous push and pop at count=2 (top 0x0007, second 0x0005) with data=0x00AA → out1=0x00AA, out2=0x0005, count=2, ready stays 1.
5. Bounds with DEPTH=4:
   - Push 1, 2, 3, 4 → full=1.
   - Push 5 → overflow pulse, count=4, out1=4.
   - Pop to empty (refills observed) → out1 sequence 3, 2, 1, 0.
   - Pop once more → underflow pulse, count=0.
6. Reset during refill, count=5: pop, then drop norst during REFILL → count=0, ready=1, out1=0, out2=0 without waiting for a clock edge. Afterwards push 0x1234 → out1=0x1234, out2=0.

Source files
------------

// File: rtl/stack_pkg.sv
// ============================================================================
// stack_pkg: shared state encoding and default sizing for the LIFO stack.
// Rev 1.0
// ============================================================================
`default_nettype none

package stack_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  localparam int WIDTH_D = 16;
  localparam int DEPTH_D = 1000;

endpackage

`default_nettype wire

// File: rtl/stack_ram.sv
// ============================================================================
// stack_ram: 1R1W synchronous RAM, one-cycle registered read, no array reset.
// Rev 1.0
// ============================================================================
`default_nettype none

module stack_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1000,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rd,
  input  logic             wr,
  input  logic [AW-1:0]    rdaddr,
  input  logic [AW-1:0]    wraddr,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] result_q;

  always_ff @(posedge clk) begin
    if (wr) begin
      mem_q[wraddr] <= in;
    end
    if (rd) begin
      result_q <= mem_q[rdaddr];
    end
  end

  assign result = result_q;

endmodule

`default_nettype wire

// File: rtl/stack_lifo.sv
// ============================================================================
// stack_lifo: push/pop LIFO; top two entries in registers, the rest in RAM.
// Rev 1.0
// ============================================================================
`default_nettype none

module stack_lifo
  import stack_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int DEPTH = DEPTH_D,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             norst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             ready,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] top_q, top_d;
  logic [WIDTH-1:0] second_q, second_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             ram_rd;
  logic             ram_wr;
  logic [AW-1:0]    ram_rdaddr;
  logic [AW-1:0]    ram_wraddr;
  logic [WIDTH-1:0] ram_result;
  logic             is_full;

  assign is_full = (count_q == CW'(DEPTH));

  // Spill slot is the entry just below 'second'; refill slot is one below that.
  assign ram_wraddr = AW'(count_q - CW'(2));
  assign ram_rdaddr = AW'(count_q - CW'(3));

  stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk    (clk),
    .rd     (ram_rd),
    .wr     (ram_wr),
    .rdaddr (ram_rdaddr),
    .wraddr (ram_wraddr),
    .in     (second_q),
    .result (ram_result)
  );

  always_ff @(posedge clk or negedge norst) begin
    if (!norst) begin
      state_q     <= IDLE;
      top_q       <= '0;
      second_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      top_q       <= top_d;
      second_q    <= second_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    top_d       = top_q;
    second_d    = second_q;
    count_d     = count_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    ram_rd      = 1'b0;
    ram_wr      = 1'b0;

    case (state_q)
      IDLE: begin
        if (push && pop) begin
          top_d = data;
          if (count_q == '0) begin
            count_d = CW'(1);
          end
        end else if (push) begin
          if (is_full) begin
            overflow_d = 1'b1;
          end else begin
            top_d    = data;
            second_d = top_q;
            count_d  = count_q + CW'(1);
            ram_wr   = (count_q >= CW'(2));
          end
        end else if (pop) begin
          if (count_q == '0) begin
            underflow_d = 1'b1;
          end else if (count_q == CW'(1)) begin
            top_d   = '0;
            count_d = '0;
          end else if (count_q == CW'(2)) begin
            top_d    = second_q;
            second_d = '0;
            count_d  = CW'(1);
          end else begin
            top_d   = second_q;
            count_d = count_q - CW'(1);
            ram_rd  = 1'b1;
            state_d = REFILL;
          end
        end
      end
      REFILL: begin
        second_d = ram_result;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // top/second are zero whenever count does not cover them, so no masking.
  assign out1      = top_q;
  assign out2      = second_q;
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = is_full;
  assign ready     = (state_q == IDLE);
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_stack_lifo.sv
// ============================================================================
// tb_stack_lifo: directed self-checking bench for stack_lifo (default and DEPTH=4).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_stack_lifo;

  logic        clk;
  logic        norst;

  logic        push, pop;
  logic [15:0] data;
  logic [15:0] out1, out2;
  logic [9:0]  count;
  logic        empty, full, ready, overflow, underflow;

  logic        push4, pop4;
  logic [15:0] data4;
  logic [15:0] out1_4, out2_4;
  logic [2:0]  count4;
  logic        empty4, full4, ready4, overflow4, underflow4;

  int checks = 0;
  int errors = 0;

  stack_lifo dut (
    .clk(clk), .norst(norst), .push(push), .pop(pop), .data(data),
    .out1(out1), .out2(out2), .count(count), .empty(empty), .full(full),
    .ready(ready), .overflow(overflow), .underflow(underflow)
  );

  stack_lifo #(.WIDTH(16), .DEPTH(4)) dut4 (
    .clk(clk), .norst(norst), .push(push4), .pop(pop4), .data(data4),
    .out1(out1_4), .out2(out2_4), .count(count4), .empty(empty4), .full(full4),
    .ready(ready4), .overflow(overflow4), .underflow(underflow4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic p, input logic q, input logic [15:0] d);
    @(negedge clk);
    push = p; pop = q; data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step4(input logic p, input logic q, input logic [15:0] d);
    @(negedge clk);
    push4 = p; pop4 = q; data4 = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    norst = 1'b0;
    push = 0; pop = 0; data = '0;
    push4 = 0; pop4 = 0; data4 = '0;
    repeat (2) @(negedge clk);
    norst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (out1 !== 16'h0) begin errors++; $display("FAIL reset_out1: got %h expected 0000", out1); end
    checks++; if (out2 !== 16'h0) begin errors++; $display("FAIL reset_out2: got %h expected 0000", out2); end
    checks++; if (count !== 10'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if ({empty, full, ready, overflow, underflow} !== 5'b10100) begin
      errors++; $display("FAIL reset_flags: got %b expected 10100", {empty, full, ready, overflow, underflow});
    end
  endtask

  task automatic test_push_pop();
    step(1, 0, 16'h0005);
    step(1, 0, 16'h0007);
    step(1, 0, 16'h0009);
    checks++; if (out1 !== 16'h0009) begin errors++; $display("FAIL push_out1: got %h expected 0009", out1); end
    checks++; if (out2 !== 16'h0007) begin errors++; $display("FAIL push_out2: got %h expected 0007", out2); end
    checks++; if (count !== 10'd3) begin errors++; $display("FAIL push_count: got %0d expected 3", count); end
    step(0, 1, 16'h0);
    checks++; if (out1 !== 16'h0007) begin errors++; $display("FAIL pop_out1: got %h expected 0007", out1); end
    checks++; if (count !== 10'd2) begin errors++; $display("FAIL pop_count: got %0d expected 2", count); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL pop_ready_low: got %b expected 0", ready); end
    // requests presented during refill must be ignored
    step(1, 0, 16'h00EE);
    checks++; if (out2 !== 16'h0005) begin errors++; $display("FAIL refill_out2: got %h expected 0005", out2); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL refill_ready: got %b expected 1", ready); end
    checks++; if (count !== 10'd2 || out1 !== 16'h0007) begin
      errors++; $display("FAIL refill_ignore: got count %0d out1 %h expected 2 0007", count, out1);
    end
    step(0, 1, 16'h0);
    checks++; if (out1 !== 16'h0005 || out2 !== 16'h0 || count !== 10'd1) begin
      errors++; $display("FAIL pop2: got %h %h %0d expected 0005 0000 1", out1, out2, count);
    end
    step(0, 1, 16'h0);
    checks++; if (out1 !== 16'h0 || out2 !== 16'h0 || count !== 10'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL pop_empty: got %h %h %0d %b expected 0000 0000 0 1", out1, out2, count, empty);
    end
    step(0, 0, 16'h0);
  endtask

  task automatic test_replace_top();
    step(1, 0, 16'h0005);
    step(1, 0, 16'h0007);
    step(1, 1, 16'h00AA);
    checks++; if (out1 !== 16'h00AA || out2 !== 16'h0005 || count !== 10'd2 || ready !== 1'b1) begin
      errors++; $display("FAIL replace: got %h %h %0d %b expected 00aa 0005 2 1", out1, out2, count, ready);
    end
    step(0, 1, 16'h0);
    step(0, 1, 16'h0);
    step(1, 1, 16'h0033);
    checks++; if (out1 !== 16'h0033 || out2 !== 16'h0 || count !== 10'd1) begin
      errors++; $display("FAIL replace_empty: got %h %h %0d expected 0033 0000 1", out1, out2, count);
    end
    step(0, 1, 16'h0);
    step(0, 0, 16'h0);
  endtask

  task automatic test_bounds();
    for (int i = 1; i <= 4; i++) step4(1, 0, 16'(i));
    checks++; if (full4 !== 1'b1 || count4 !== 3'd4) begin
      errors++; $display("FAIL bound_full: got full %b count %0d expected 1 4", full4, count4);
    end
    step4(1, 0, 16'h0005);
    checks++; if (overflow4 !== 1'b1 || count4 !== 3'd4 || out1_4 !== 16'h0004) begin
      errors++; $display("FAIL overflow: got ovf %b count %0d out1 %h expected 1 4 0004", overflow4, count4, out1_4);
    end
    step4(1, 1, 16'h0004);
    checks++; if (overflow4 !== 1'b0 || count4 !== 3'd4 || out1_4 !== 16'h0004) begin
      errors++; $display("FAIL full_replace: got ovf %b count %0d out1 %h expected 0 4 0004", overflow4, count4, out1_4);
    end
    step4(0, 1, 16'h0);
    checks++; if (out1_4 !== 16'h0003 || ready4 !== 1'b0) begin
      errors++; $display("FAIL bpop3: got %h ready %b expected 0003 0", out1_4, ready4);
    end
    step4(0, 0, 16'h0);
    checks++; if (out2_4 !== 16'h0002) begin errors++; $display("FAIL brefill2: got %h expected 0002", out2_4); end
    step4(0, 1, 16'h0);
    checks++; if (out1_4 !== 16'h0002) begin errors++; $display("FAIL bpop2: got %h expected 0002", out1_4); end
    step4(0, 0, 16'h0);
    checks++; if (out2_4 !== 16'h0001) begin errors++; $display("FAIL brefill1: got %h expected 0001", out2_4); end
    step4(0, 1, 16'h0);
    checks++; if (out1_4 !== 16'h0001 || out2_4 !== 16'h0) begin
      errors++; $display("FAIL bpop1: got %h %h expected 0001 0000", out1_4, out2_4);
    end
    step4(0, 1, 16'h0);
    checks++; if (out1_4 !== 16'h0 || count4 !== 3'd0 || empty4 !== 1'b1) begin
      errors++; $display("FAIL bpop0: got %h %0d %b expected 0000 0 1", out1_4, count4, empty4);
    end
    step4(0, 1, 16'h0);
    checks++; if (underflow4 !== 1'b1 || count4 !== 3'd0) begin
      errors++; $display("FAIL underflow: got %b count %0d expected 1 0", underflow4, count4);
    end
    step4(0, 0, 16'h0);
    checks++; if (underflow4 !== 1'b0) begin errors++; $display("FAIL underflow_pulse: got %b expected 0", underflow4); end
  endtask

  task automatic test_reset_in_refill();
    do_reset();
    for (int i = 1; i <= 5; i++) step(1, 0, 16'(i));
    step(0, 1, 16'h0);
    checks++; if (ready !== 1'b0 || count !== 10'd4) begin
      errors++; $display("FAIL rr_refill: got ready %b count %0d expected 0 4", ready, count);
    end
    pop = 1'b0;
    norst = 1'b0;
    #1;
    checks++; if (count !== 10'd0 || ready !== 1'b1 || out1 !== 16'h0 || out2 !== 16'h0) begin
      errors++; $display("FAIL rr_async: got %0d %b %h %h expected 0 1 0000 0000", count, ready, out1, out2);
    end
    @(negedge clk);
    norst = 1'b1;
    step(1, 0, 16'h1234);
    checks++; if (out1 !== 16'h1234 || out2 !== 16'h0 || count !== 10'd1) begin
      errors++; $display("FAIL rr_push: got %h %h %0d expected 1234 0000 1", out1, out2, count);
    end
    step(0, 0, 16'h0);
  endtask

  initial begin
    norst = 1'b1;
    push = 0; pop = 0; data = '0;
    push4 = 0; pop4 = 0; data4 = '0;
    test_reset();
    test_push_pop();
    test_replace_top();
    test_bounds();
    test_reset_in_refill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
